// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared widths, FSM states and command record for the memory access arbiter
package mem_ctrl_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} state_e;
  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } mem_cmd_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first set request at or after the pointer, wrapping
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [IDX_W-1:0]   idx_o
);
  // scan farthest-to-nearest so the nearest set bit overwrites earlier picks
  always_comb begin
    win_o = '0;
    idx_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (en_i && req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
        win_o = '0;
        win_o[(int'(ptr_i) + k) % NUM_REQ] = 1'b1;
        idx_o = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: round-robin sharing of one single-port memory between NUM_REQ requesters
module mem_access_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int READ_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_data_in,
  output logic                      mem_read,
  output logic                      mem_write,
  input  logic [DATA_W-1:0]         mem_data_out
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = 2;
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, idx_q, idx_d, win_idx;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [NUM_REQ-1:0] win, gnt_q, gnt_d, done_q, done_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d, mem_data_in_q, mem_data_in_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic               grant, rd_last;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .en_i  (state_q == IDLE),
    .win_o (win),
    .idx_o (win_idx)
  );
  assign grant   = |win;
  assign rd_last = state_q == RD_WAIT && cnt_q == '0;
  // state and registered outputs; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      gnt_q         <= '0;
      done_q        <= '0;
      rdata_q       <= '0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      we_q          <= we_d;
      gnt_q         <= gnt_d;
      done_q        <= done_d;
      rdata_q       <= rdata_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
    end
  end
  // sequencing: grant in IDLE, one access cycle, then count out the read latency
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d = ACCESS;
        ptr_d   = win_idx == IDX_W'(NUM_REQ - 1) ? '0 : win_idx + 1'b1;
        idx_d   = win_idx;
        we_d    = req_we[win_idx];
      end
      ACCESS: begin
        state_d = we_q ? IDLE : RD_WAIT;
        cnt_d   = CNT_W'(READ_LAT - 1);
      end
      RD_WAIT: begin
        state_d = rd_last ? IDLE : RD_WAIT;
        cnt_d   = rd_last ? cnt_q : cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // next values of the registered outputs; the read strobe spans exactly READ_LAT cycles
  always_comb begin
    gnt_d         = state_q == IDLE ? win : '0;
    done_d        = ((state_q == ACCESS && we_q) || rd_last) ? NUM_REQ'(1) << idx_q : '0;
    mem_write_d   = grant && req_we[win_idx];
    mem_read_d    = grant ? !req_we[win_idx] :
                    state_q == ACCESS ? !we_q && (READ_LAT > 1) :
                    state_q == RD_WAIT && cnt_q > CNT_W'(1);
    mem_addr_d    = grant ? req_addr[int'(win_idx)*ADDR_W +: ADDR_W] : mem_addr_q;
    mem_data_in_d = mem_write_d ? req_wdata[int'(win_idx)*DATA_W +: DATA_W] : mem_data_in_q;
    rdata_d       = rd_last ? mem_data_out : rdata_q;
  end
  assign gnt         = gnt_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed and random stimulus against a transaction-schedule reference model
module tb_mem_access_arbiter;
  localparam int NR = 3, AW = 5, DW = 8, RL = 3, MAXC = 4096;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NR-1:0] req = '0, req_we = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0] gnt, done;
  logic [DW-1:0] rdata, mem_data_in, mem_data_out;
  logic [AW-1:0] mem_addr;
  logic mem_read, mem_write;
  always #5 clk = ~clk;
  mem_access_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_read(mem_read), .mem_write(mem_write),
    .mem_data_out(mem_data_out)
  );
  // scratch memory: data for a read strobed in cycle t appears in cycle t+RL
  bit [DW-1:0] mem [32];
  logic [DW-1:0] pipe [RL];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_data_in;
    pipe[0] <= mem_read ? mem[mem_addr] : 8'hEE;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_data_out = pipe[RL-1];
  // reference model: per-cycle expected events scheduled at grant time
  bit [DW-1:0] ref_mem [32];
  logic [NR-1:0] eg [MAXC], ed [MAXC];
  logic ew [MAXC], er [MAXC], erv [MAXC];
  logic [AW-1:0] ea [MAXC];
  logic [DW-1:0] edin [MAXC], erd [MAXC];
  logic [DW-1:0] cur_rd = '0;
  int cyc = 0, idle_from = 0, ptr = 0, mode = 0;
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask
  task automatic clear_from(input int c);
    for (int t = c; t < MAXC; t++) begin
      eg[t] = '0; ed[t] = '0; ew[t] = 1'b0; er[t] = 1'b0; erv[t] = 1'b0;
      ea[t] = '0; edin[t] = '0; erd[t] = '0;
    end
  endtask
  task automatic model();
    int j;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    j = 0;
    if (rst_n && cyc - 1 >= idle_from && req != '0) begin
      for (int k = NR - 1; k >= 0; k--) if (req[(ptr + k) % NR]) j = (ptr + k) % NR;
      a = req_addr[j*AW +: AW];
      d = req_wdata[j*DW +: DW];
      eg[cyc] = NR'(1) << j;
      ptr = (j + 1) % NR;
      if (req_we[j]) begin
        ew[cyc] = 1'b1; ea[cyc] = a; edin[cyc] = d;
        ed[cyc+1] = NR'(1) << j;
        ref_mem[a] = d;
        idle_from = cyc + 1;
      end else begin
        for (int t = 0; t < RL; t++) begin er[cyc+t] = 1'b1; ea[cyc+t] = a; end
        ed[cyc+RL+1] = NR'(1) << j;
        erv[cyc+RL+1] = 1'b1; erd[cyc+RL+1] = ref_mem[a];
        idle_from = cyc + RL + 1;
      end
    end
  endtask
  task automatic compare();
    if (erv[cyc]) cur_rd = erd[cyc];
    chk("gnt", gnt, eg[cyc]);
    chk("done", done, ed[cyc]);
    chk("mem_write", mem_write, ew[cyc]);
    chk("mem_read", mem_read, er[cyc]);
    chk("strobe_excl", mem_read & mem_write, 0);
    chk("rdata", rdata, cur_rd);
    if (ew[cyc] || er[cyc]) chk("mem_addr", mem_addr, ea[cyc]);
    if (ew[cyc]) chk("mem_data_in", mem_data_in, edin[cyc]);
  endtask
  task automatic new_cmd(input int i);
    req[i] = 1'b1;
    req_we[i] = 1'($urandom_range(0, 1));
    req_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
    req_wdata[i*DW +: DW] = DW'($urandom);
  endtask
  task automatic drive();
    if (mode == 0) req = req & ~gnt;
    else if (mode == 2) begin
      for (int i = 0; i < NR; i++) begin
        if (gnt[i]) begin
          if ($urandom_range(0, 2) != 0) req[i] = 1'b0; else new_cmd(i);
        end else if (req[i]) begin
          if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) new_cmd(i);
      end
    end
  endtask
  task automatic step(input int n);
    for (int s = 0; s < n; s++) begin
      @(posedge clk);
      cyc++;
      model();
      @(negedge clk);
      compare();
      drive();
    end
  endtask
  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1; req_we[i] = we; req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d;
  endtask
  initial begin
    clear_from(0);
    step(3);
    rst_n = 1'b1;
    step(1);
    set_req(0, 1'b1, 5'd3, 8'hA5);
    step(4);
    set_req(1, 1'b0, 5'd3, 8'h00);
    step(RL + 4);
    mode = 1;
    set_req(0, 1'b1, 5'd10, 8'h11);
    set_req(1, 1'b1, 5'd11, 8'h22);
    step(10);
    mode = 0;
    req = '0;
    step(2);
    set_req(2, 1'b1, 5'd31, 8'h3C);
    step(4);
    set_req(0, 1'b0, 5'd31, 8'h00);
    step(RL + 4);
    set_req(1, 1'b0, 5'd31, 8'h00);
    step(2);
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    clear_from(cyc);
    cur_rd = '0; ptr = 0; idle_from = cyc;
    req = '0;
    step(2);
    set_req(0, 1'b1, 5'd7, 8'h5A);
    set_req(1, 1'b1, 5'd8, 8'h6B);
    rst_n = 1'b1;
    step(6);
    set_req(0, 1'b1, 5'd4, 8'h77);
    set_req(1, 1'b1, 5'd5, 8'h88);
    step(1);
    req[1] = 1'b0;
    step(6);
    mode = 2;
    step(2000);
    mode = 0;
    req = '0;
    step(RL + 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Shares the single-port 32x8 scratch memory (addr/data_in/data_out, read/write strobes) between NUM_REQ requesters.
- Uses round-robin arbitration and a small FSM that sequences each write or read access, including read-latency wait and data capture.
- Sits between requester agents (testbench drivers, DMA/CPU stubs) and the memory, replacing direct strobe driving by each agent.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 5, memory address width
- DATA_W, 8, memory data width
- READ_LAT, 1, cycles from mem_read assertion to valid mem_data_out (1..4)

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester request level, held until gnt
- req_we  in  NUM_REQ  1=write, 0=read, per requester
- req_addr  in  NUM_REQ*ADDR_W  packed per-requester address
- req_wdata  in  NUM_REQ*DATA_W  packed per-requester write data
- gnt  out  NUM_REQ  one-hot, one-cycle pulse: command accepted
- done  out  NUM_REQ  one-hot, one-cycle pulse: access complete
- rdata  out  DATA_W  read result, valid when done pulses for a read
- mem_addr  out  ADDR_W  memory address
- mem_data_in  out  DATA_W  memory write data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_data_out  in  DATA_W  memory read data

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0 and state is IDLE.
  - The round-robin pointer gives requester 0 highest priority.
  - Reset asserted in any state aborts the access: no done, strobes drop immediately.
- States: IDLE, ACCESS, RD_WAIT. All outputs are registered.
- IDLE:
  - If any req bit is set, the arbiter picks the winner: the first set bit at or after the pointer, wrapping.
  - On the clock edge it latches we/addr/wdata, pulses gnt[winner] and moves to ACCESS.
  - The pointer then advances to winner+1 mod NUM_REQ.
  - If no req is set, the pointer is unchanged.
- ACCESS, write (grant cycle G):
  - mem_write=1, mem_addr/mem_data_in driven from the latched command for exactly cycle G.
  - Next state IDLE; done[winner] pulses in G+1.
- ACCESS, read:
  - mem_read=1 and mem_addr driven from G.
  - Next state RD_WAIT, with counter loaded with READ_LAT-1. For READ_LAT=1, capture at the end of G+1.
- RD_WAIT:
  - mem_read and mem_addr are held.
  - The counter decrements each cycle.
  - When mem_data_out is valid (cycle G+READ_LAT), it is sampled into rdata, mem_read drops, and the FSM goes to IDLE.
  - done[winner] pulses in G+READ_LAT+1.
  - Read latency from grant is READ_LAT+1 cycles.
- Back-to-back accesses:
  - Arbitration runs in the IDLE cycle where done pulses, so the next gnt can occur at done cycle +1.
  - Peak rate is one write per 2 cycles and one read per READ_LAT+2 cycles.
- Requester rules:
  - req must be held until gnt. Deasserting before gnt withdraws it silently.
  - req still high after gnt is a new request.
  - The latched command is immune to input changes after gnt.
- Idle memory outputs:
  - mem_addr and mem_data_in hold their last values.
  - Strobes are 0 outside ACCESS/RD_WAIT.
  - mem_read and mem_write are never both 1.
- rdata holds its value until the next read capture. It is undefined-meaning, though stable, after a write.
- Fairness: with all requesters continuously requesting, grants rotate strictly. No requester waits more than NUM_REQ-1 other accesses.

Decomposition:
- Package mem_ctrl_pkg holds:
  - ADDR_W/DATA_W defaults (5/8)
  - state enum typedef (IDLE, ACCESS, RD_WAIT)
  - mem_cmd_t struct {we, addr, wdata}
- One sub-module, rr_arbiter (parameter NUM_REQ):
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot winner and winner index.
  - Pointer update stays in the top-level FSM.

Test Plan:
- Reset, then req[0] write addr=5'd3 data=8'hA5 → gnt[0] 1 cycle later, mem_write=1 for exactly 1 cycle with mem_addr=3, mem_data_in=A5, done[0] the next cycle.
- Then req[1] read addr=3 (READ_LAT=1) → mem_read high 1 cycle, done[1] 2 cycles after gnt, rdata=8'hA5.
- req[0] and req[1] both held continuously, all writes → gnt sequence 0,1,0,1; no strobe overlap; each gnt exactly 2 cycles apart.
- READ_LAT=3 build: read addr=31 pre-written 8'h3C → mem_read held 3 cycles, done 4 cycles after gnt, rdata=8'h3C.
- rst_n pulled low during RD_WAIT → strobes, gnt and done go to 0 asynchronously; no done after release; next grant goes to requester 0.
- req[1] raised then dropped in the same IDLE cycle that req[0] wins → only gnt[0] issued; no access for requester 1.
